// File: rtl/alu_mul_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq_if
//  Description : Bus between the CPU datapath, the multiply sequencer and the
//                shared 32-bit ALU.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_mul_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] cpu_x;
    logic [31:0] cpu_y;
    logic [1:0]  cpu_aluc;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [1:0]  alu_aluc;
    logic [31:0] alu_r;
    logic        busy;
    logic        done;
    logic [31:0] product;

    modport master (
        output start, a, b, cpu_x, cpu_y, cpu_aluc, alu_r,
        input  alu_x, alu_y, alu_aluc, busy, done, product
    );

    modport slave (
        input  start, a, b, cpu_x, cpu_y, cpu_aluc, alu_r,
        output alu_x, alu_y, alu_aluc, busy, done, product
    );
endinterface
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Shift-and-add unsigned multiplier that borrows the shared
//                ALU's add path while busy; passes CPU operands through idle.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_mul_seq (
    input  wire logic      clk,
    input  wire logic      rst,
    alu_mul_seq_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] C_ALU_ADD = 2'b00;

    logic [1:0]  r_state;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic [31:0] r_product;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_acc_next;
    logic [31:0] w_mplier_next;

    // The ALU computes acc + mcand this cycle; keep it only for a set multiplier bit.
    assign w_acc_next    = r_mplier[0] ? bus.alu_r : r_acc;
    assign w_mplier_next = r_mplier >> 1;

    always_comb begin
        bus.alu_x    = bus.cpu_x;
        bus.alu_y    = bus.cpu_y;
        bus.alu_aluc = bus.cpu_aluc;
        if (r_busy) begin
            bus.alu_x    = r_acc;
            bus.alu_y    = r_mcand;
            bus.alu_aluc = C_ALU_ADD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= 32'd0;
            r_mplier  <= 32'd0;
            r_acc     <= 32'd0;
            r_product <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_mcand  <= bus.a;
                        r_mplier <= bus.b;
                        r_acc    <= 32'd0;
                        r_busy   <= 1'b1;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    // Stop once no set multiplier bits remain; b=0 still costs one cycle.
                    if (w_mplier_next == 32'd0) begin
                        r_product <= w_acc_next;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
endmodule
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mul_seq
//  Description : Scoreboard bench for alu_mul_seq with a behavioural shared ALU.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_mul_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [31:0] sb_q[$];

    alu_mul_seq_if bus ();

    alu_mul_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-cycle ALU sharing the bus.
    always_comb begin
        case (bus.alu_aluc)
            2'b00:   bus.alu_r = bus.alu_x + bus.alu_y;
            2'b01:   bus.alu_r = bus.alu_x - bus.alu_y;
            2'b10:   bus.alu_r = bus.alu_x & bus.alu_y;
            default: bus.alu_r = bus.alu_x | bus.alu_y;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_mul(input logic [31:0] ta, input logic [31:0] tb_v, input int exp_n);
        int          n;
        logic [31:0] exp_p;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        sb_q.push_back(ta * tb_v);
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            chk("busy_aluc", {30'd0, bus.alu_aluc}, 32'd0);
            @(negedge clk);
        end
        chk("busy_len", n, exp_n);
        chk("done_pulse", {31'd0, bus.done}, 32'd1);
        chk("done_passthru_x", bus.alu_x, bus.cpu_x);
        exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
        chk("product", bus.product, exp_p);
        @(negedge clk);
        chk("done_clear", {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        int          n_done;
        int          last_done;
        logic        prev_busy;
        logic [31:0] exp_p;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        bus.cpu_x = 32'd5;
        bus.cpu_y = 32'd3;
        bus.cpu_aluc = 2'b01;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("idle_alu_x", bus.alu_x, 32'd5);
        chk("idle_alu_y", bus.alu_y, 32'd3);
        chk("idle_alu_aluc", {30'd0, bus.alu_aluc}, 32'd1);
        chk("reset_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
        chk("reset_product", bus.product, 32'd0);

        bus.cpu_x = 32'hDEAD_0001;
        run_mul(32'd6, 32'd7, 3);
        run_mul(32'h1234_5678, 32'd0, 1);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
        run_mul(32'h8000_0000, 32'd2, 2);
        run_mul(32'd3, 32'h8000_0000, 32);

        // Abort in the 10th busy cycle; a cleared product and no done pulse follow.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'd1;
        bus.b = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_product", bus.product, 32'd0);
        chk("abort_pass_x", bus.alu_x, bus.cpu_x);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        run_mul(32'd2, 32'd3, 2);

        // Start held high: a new multiply every N+2 = 5 cycles.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'd5;
        bus.b = 32'd5;
        prev_busy = 1'b0;
        n_done = 0;
        last_done = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (bus.busy === 1'b1 && !prev_busy) sb_q.push_back(32'd25);
            prev_busy = bus.busy;
            if (bus.done === 1'b1) begin
                exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
                chk("held_product", bus.product, exp_p);
                if (last_done >= 0) chk("held_period", cyc - last_done, 5);
                last_done = cyc;
                n_done++;
            end
        end
        bus.start = 1'b0;
        chk("held_done_count", n_done, 6);
        repeat (6) @(negedge clk);
        sb_q.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
